// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle ARM-subset datapath.
// Holds the main FSM, the instruction decoder and the condition/flag logic.
// Optional feature macro: MC_PERF_COUNTERS_EN enables the retired-instruction
// and cycle counters; without it both counter outputs are tied to zero.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic [3:0]       ALUFlags,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ALUControl,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t     state, state_next;
    logic [3:0] nzcv;          // architectural flag register {N,Z,C,V}
    logic       cond_reg;      // condition result latched at the end of DECODE
    logic       cond_ex;
    logic       pc_en, reg_en, mem_en, ir_en;

    // Instruction fields that this unit never looks at (Rn, operand2/offset).
    logic unused_instr;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    // Decoder: classify the instruction and pick its ALU operation.
    logic [1:0] op;
    logic       dp_ok, dp_arith, dp_cmp;
    logic [1:0] dp_alu;
    logic       is_dp, is_cmp, is_mem, is_b, is_nop, is_str, rd_pc, flag_w;
    logic [1:0] dec_alu;

    assign op = Instr[27:26];

    // Data-processing command decode; unknown commands fall through as NOP.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        dp_ok    = 1'b1;
        dp_arith = 1'b0;
        dp_cmp   = 1'b0;
        dp_alu   = 2'b00;
        case (Instr[24:21])
            4'b0100: begin dp_alu = 2'b00; dp_arith = 1'b1; end                // ADD
            4'b0010: begin dp_alu = 2'b01; dp_arith = 1'b1; end                // SUB
            4'b0000: dp_alu = 2'b10;                                           // AND
            4'b1100: dp_alu = 2'b11;                                           // ORR
            4'b1010: begin dp_alu = 2'b01; dp_arith = 1'b1; dp_cmp = 1'b1; end // CMP
            default: dp_ok = 1'b0;
        endcase
    end

    assign is_dp   = (op == 2'b00) && dp_ok;
    assign is_cmp  = is_dp && dp_cmp;
    assign is_mem  = (op == 2'b01);
    assign is_b    = (op == 2'b10);
    assign is_nop  = !(is_dp || is_mem || is_b);
    assign is_str  = is_mem && !Instr[20];
    assign rd_pc   = (Instr[15:12] == 4'hF);
    assign flag_w  = is_dp && Instr[20];
    // Memory offsets subtract when U=0; branches and NOPs add.
    assign dec_alu = is_dp ? dp_alu : ((is_mem && !Instr[23]) ? 2'b01 : 2'b00);

    // Condition evaluation against the stored flags.
    always_comb begin
        cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: cond_ex = nzcv[2];                              // EQ
            4'b0001: cond_ex = !nzcv[2];                             // NE
            4'b0010: cond_ex = nzcv[1];                              // CS
            4'b0011: cond_ex = !nzcv[1];                             // CC
            4'b0100: cond_ex = nzcv[3];                              // MI
            4'b0101: cond_ex = !nzcv[3];                             // PL
            4'b0110: cond_ex = nzcv[0];                              // VS
            4'b0111: cond_ex = !nzcv[0];                             // VC
            4'b1000: cond_ex = nzcv[1] && !nzcv[2];                  // HI
            4'b1001: cond_ex = !nzcv[1] || nzcv[2];                  // LS
            4'b1010: cond_ex = (nzcv[3] == nzcv[0]);                 // GE
            4'b1011: cond_ex = (nzcv[3] != nzcv[0]);                 // LT
            4'b1100: cond_ex = !nzcv[2] && (nzcv[3] == nzcv[0]);     // GT
            4'b1101: cond_ex = nzcv[2] || (nzcv[3] != nzcv[0]);      // LE
            4'b1110: cond_ex = 1'b1;                                 // AL
            default: cond_ex = 1'b0;                                 // never
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // Condition latch and flag register updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv     <= 4'b0000;
            cond_reg <= 1'b0;
        end else begin
            if (state == DECODE) cond_reg <= cond_ex;
            if ((state == EXECR || state == EXECI) && cond_reg && flag_w) begin
                nzcv[3:2] <= ALUFlags[3:2];
                if (dp_arith) nzcv[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_next = FETCH;
        pc_en      = 1'b0;
        reg_en     = 1'b0;
        mem_en     = 1'b0;
        ir_en      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        case (state)
            FETCH: begin
                ir_en = 1'b1; pc_en = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                if (is_mem)                 state_next = MEMADR;
                else if (is_b)              state_next = BRANCH;
                else if (is_dp && Instr[25]) state_next = EXECI;
                else                        state_next = EXECR;
            end
            MEMADR: begin
                ALUSrcB = 2'b01; ImmSrc = 2'b01;
                state_next = Instr[20] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                pc_en  = cond_reg && rd_pc;
                reg_en = cond_reg && !rd_pc;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_en = cond_reg;
            end
            EXECR: state_next = (is_cmp || is_nop) ? FETCH : ALUWB;
            EXECI: begin
                ALUSrcB = 2'b01;
                state_next = (is_cmp || is_nop) ? FETCH : ALUWB;
            end
            ALUWB: begin
                pc_en  = cond_reg && rd_pc;
                reg_en = cond_reg && !rd_pc;
            end
            BRANCH: begin
                ALUSrcB = 2'b01; ImmSrc = 2'b10; ResultSrc = 2'b10;
                pc_en = cond_reg;
            end
            default: state_next = FETCH;
        endcase
    end

    // Enables are gated by reset so nothing is written while it is held.
    assign PCWrite    = pc_en  && reset;
    assign RegWrite   = reg_en && reset;
    assign MemWrite   = mem_en && reset;
    assign IRWrite    = ir_en  && reset;
    // Register-port selects and ALU op stay fixed once the instruction is decoded.
    assign RegSrc     = (state == FETCH) ? 2'b00 : {is_str, is_b};
    assign ALUControl = (state == FETCH || state == DECODE) ? 2'b00 : dec_alu;
    assign State      = state;

`ifdef MC_PERF_COUNTERS_EN
    logic retire;
    assign retire = (state_next == FETCH) &&
                    (state inside {MEMWB, MEMWR, ALUWB, BRANCH, EXECR, EXECI});

    // Performance counters: free-running cycles and retired instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instructions checked against a
// behavioural model of the controller (per-class state sequences, flag register,
// condition codes, counters). Counter checks follow MC_PERF_COUNTERS_EN.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  State;
    logic [31:0] instr_count, cycle_count;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef enum int { C_DP, C_CMP, C_LDR, C_STR, C_B, C_NOP } cls_t;

    typedef struct packed {
        logic       pcw, regw, memw, irw, adr;
        logic [1:0] regsrc, srca, srcb, res, imm, aluc;
    } ctrl_t;

    ctrl_t dut_c;
    assign dut_c = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc,
                    RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  flags_m;       // model flag register {N,Z,C,V}
    int unsigned cyc_m, ins_m;  // model counters

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] ins);
        case (ins[27:26])
            2'b01: return ins[20] ? C_LDR : C_STR;
            2'b10: return C_B;
            2'b00: begin
                if (ins[24:21] == 4'b1010) return C_CMP;
                if (ins[24:21] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100}) return C_DP;
                return C_NOP;
            end
            default: return C_NOP;
        endcase
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n = f[3], z = f[2], c = f[1], v = f[0];
        case (cc)
            4'h0: return z;          4'h1: return !z;
            4'h2: return c;          4'h3: return !c;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return c && !z;    4'h9: return !c || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [31:0] ins, input cls_t cls);
        if (cls == C_DP || cls == C_CMP) begin
            case (ins[24:21])
                4'b0100: return 2'b00;
                4'b0000: return 2'b10;
                4'b1100: return 2'b11;
                default: return 2'b01;   // SUB and CMP
            endcase
        end
        if (cls == C_LDR || cls == C_STR) return ins[23] ? 2'b00 : 2'b01;
        return 2'b00;
    endfunction

    // Expected controls for one state of an instruction, straight from the state table.
    function automatic ctrl_t exp_ctrl(input int st, input cls_t cls, input logic [31:0] ins,
                                       input logic cond);
        ctrl_t c = '0;
        logic  rd_pc = (ins[15:12] == 4'hF);
        if (st >= 1) c.regsrc = {cls == C_STR, cls == C_B};
        if (st >= 2) c.aluc = alu_of(ins, cls);
        case (st)
            0: begin c.irw = 1; c.pcw = 1; c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
            1: begin c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10; end
            2: begin c.srcb = 2'b01; c.imm = 2'b01; end
            3: c.adr = 1;
            4: begin c.res = 2'b01; c.regw = cond && !rd_pc; c.pcw = cond && rd_pc; end
            5: begin c.adr = 1; c.memw = cond; end
            7: c.srcb = 2'b01;
            8: begin c.regw = cond && !rd_pc; c.pcw = cond && rd_pc; end
            9: begin c.srcb = 2'b01; c.imm = 2'b10; c.res = 2'b10; c.pcw = cond; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check_counters(input string tag);
`ifdef MC_PERF_COUNTERS_EN
        check({tag, "_instr_count"}, instr_count, ins_m);
        check({tag, "_cycle_count"}, cycle_count, cyc_m);
`else
        check({tag, "_instr_count"}, instr_count, 32'd0);
        check({tag, "_cycle_count"}, cycle_count, 32'd0);
`endif
    endtask

    // Runs one whole instruction; entered and left just after a falling edge in FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        cls_t cls  = classify(ins);
        logic cond = cond_ok(ins[31:28], flags_m);
        int   seq[$];
        case (cls)
            C_B:     seq = '{0, 1, 9};
            C_LDR:   seq = '{0, 1, 2, 3, 4};
            C_STR:   seq = '{0, 1, 2, 5};
            C_CMP:   seq = ins[25] ? '{0, 1, 7} : '{0, 1, 6};
            C_DP:    seq = ins[25] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            default: seq = '{0, 1, 6};
        endcase
        Instr    = ins;
        ALUFlags = af;
        #1;
        check_counters("start");
        foreach (seq[k]) begin
            if (k > 0) #1;
            check($sformatf("state_%08h_%0d", ins, k), 32'(State), 32'(seq[k]));
            check($sformatf("ctrl_%08h_s%0d", ins, seq[k]), {15'b0, dut_c},
                  {15'b0, exp_ctrl(seq[k], cls, ins, cond)});
            @(posedge clk);
            cyc_m++;
            if ((seq[k] == 6 || seq[k] == 7) && cond && ins[20] && (cls == C_DP || cls == C_CMP)) begin
                flags_m[3:2] = af[3:2];
                if (ins[24:21] inside {4'b0100, 4'b0010, 4'b1010}) flags_m[1:0] = af[1:0];
            end
            @(negedge clk);
        end
        ins_m++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] cc  = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
        logic [1:0] op  = 2'($urandom_range(0, 3));
        logic [3:0] cmd;
        logic [3:0] rd  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        case ($urandom_range(0, 5))
            0: cmd = 4'b0100;
            1: cmd = 4'b0010;
            2: cmd = 4'b0000;
            3: cmd = 4'b1100;
            4: cmd = 4'b1010;
            default: cmd = 4'($urandom_range(0, 15));
        endcase
        return {cc, op, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), rd, 12'($urandom_range(0, 4095))};
    endfunction

    ctrl_t fetch_rst;

    initial begin
        reset    = 1'b0;
        Instr    = '0;
        ALUFlags = '0;
        flags_m  = '0;
        cyc_m    = 0;
        ins_m    = 0;
        fetch_rst = exp_ctrl(0, C_NOP, 32'h0, 1'b0);
        fetch_rst.pcw = 0;
        fetch_rst.irw = 0;

        // Held in reset: FETCH, enables off, FETCH mux selects.
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 32'(State), 32'd0);
        check("reset_ctrl", {15'b0, dut_c}, {15'b0, fetch_rst});
        check_counters("reset");
        @(negedge clk);
        reset = 1'b1;

        // ADD, LDR, STR from reset.
        run_instr(32'hE0821003, 4'h0);
        run_instr(32'hE5910004, 4'h0);
`ifdef MC_PERF_COUNTERS_EN
        check("second_fetch_instr_count", instr_count, 32'd2);
        check("second_fetch_cycle_count", cycle_count, 32'd9);
`endif
        run_instr(32'hE5810004, 4'h0);

        // SUBS sets Z, BEQ taken; SUBS clears flags, BEQ not taken.
        run_instr(32'hE0500000, 4'b0100);
        run_instr(32'h0A000002, 4'h0);
        run_instr(32'hE0500000, 4'b0000);
        run_instr(32'h0A000002, 4'h0);
        // CMP immediate, LDR into PC, subtract-offset STR, never-condition ADD.
        run_instr(32'hE3500005, 4'b1011);
        run_instr(32'hE591F004, 4'h0);
        run_instr(32'hE5010004, 4'h0);
        run_instr(32'hF0821003, 4'h0);

        // Reset in MEMWR of a STR aborts it at once.
        Instr = 32'hE5810004;
        ALUFlags = 4'h0;
        repeat (3) begin
            @(posedge clk);
            cyc_m++;
            @(negedge clk);
        end
        #1;
        check("memwr_state", 32'(State), 32'd5);
        check("memwr_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        check("abort_state", 32'(State), 32'd0);
        check("abort_ctrl", {15'b0, dut_c}, {15'b0, fetch_rst});
        flags_m = '0;
        cyc_m   = 0;
        ins_m   = 0;
        @(negedge clk);
        reset = 1'b1;
        run_instr(32'hE5810004, 4'h0);
        run_instr(32'h0A000002, 4'h0);   // flags cleared: EQ fails
        run_instr(32'h1A000002, 4'h0);   // NE passes

        // Random instruction stream against the model.
        for (int i = 0; i < 200; i++) run_instr(rand_instr(), 4'($urandom_range(0, 15)));
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
